// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the RV32I execute stage and a single-port word memory.
// One command at a time: legality check, store lane steering, registered-read wait and
// load formatting, with a single-cycle done/err pulse at the end.
module lsu_mem_initiator #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data,
  output logic                  request,
  output logic                  we_re,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           data_in,
  output logic [3:0]            mask,
  input  logic [31:0]           data_out
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           sd_q;
  logic                  err_q;
  logic [31:0]           load_data_q;

  logic                  accept;
  logic                  f3_legal;
  logic                  misaligned;
  logic                  cmd_err;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_fmt;

  // Byte-address bits above the word-address range are ignored.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  // Classify the incoming command as legal or erroring.
  always_comb begin
    f3_legal = 1'b0;
    if (is_store) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    cmd_err    = !f3_legal || misaligned;
  end

  // Next-state logic; a command is only accepted from idle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = cmd_err ? StDone : StReq;
        end
      end
      StReq:   state_d = is_store_q ? StDone : StWait;
      StWait:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Extract and extend the addressed lane of the memory read word.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   ld_byte = data_out[7:0];
      2'b01:   ld_byte = data_out[15:8];
      2'b10:   ld_byte = data_out[23:16];
      default: ld_byte = data_out[31:24];
    endcase
    ld_half = addr_q[1] ? data_out[31:16] : data_out[15:0];
    unique case (funct3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'h000000, ld_byte};
      3'b101:  ld_fmt = {16'h0000, ld_half};
      default: ld_fmt = data_out;
    endcase
  end

  // State and command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      sd_q        <= 32'h0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr[ADDR_WIDTH+1:0];
        sd_q       <= store_data;
        err_q      <= cmd_err;
      end
      if (state_q == StWait) begin
        load_data_q <= ld_fmt;
      end
    end
  end

  // Memory-side outputs are driven only in REQ; request is gated by reset so a
  // reset edge landing in REQ never commits a memory access.
  always_comb begin
    request = 1'b0;
    we_re   = 1'b0;
    address = '0;
    data_in = 32'h0;
    mask    = 4'b0000;
    if (state_q == StReq) begin
      request = rst;
      we_re   = is_store_q;
      address = addr_q[ADDR_WIDTH+1:2];
      if (is_store_q) begin
        unique case (funct3_q[1:0])
          2'b00: begin
            mask    = 4'b0001 << addr_q[1:0];
            data_in = {4{sd_q[7:0]}};
          end
          2'b01: begin
            mask    = addr_q[1] ? 4'b1100 : 4'b0011;
            data_in = {2{sd_q[15:0]}};
          end
          2'b10: begin
            mask    = 4'b1111;
            data_in = sd_q;
          end
          default: begin
            mask    = 4'b0000;
            data_in = 32'h0;
          end
        endcase
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StDone) && err_q;
  assign load_data = load_data_q;

endmodule
